// File: rtl/srmem_rd_sched_pkg.sv
// rtl/srmem_rd_sched_pkg.sv - shared FSM states, sizing macro and build defaults for srmem_rd_sched
`ifndef SRMEM_RD_SCHED_PKG_SV
`define SRMEM_RD_SCHED_PKG_SV

// Counter width over x values; never narrower than one bit.
`ifndef LOG2
`define LOG2(x) (((x) <= 2) ? 1 : $clog2(x))
`endif

package srmem_rd_sched_pkg;

    localparam int NUM_PCU_DEF    = 2;
    localparam int NUM_PCH_DEF    = 4;
    localparam int PCHINFO_BW_DEF = 32;
    localparam int LEN_SRMEM_DEF  = NUM_PCH_DEF / NUM_PCU_DEF;
    localparam int TIMEOUT_DEF    = 1024;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_SERVE = 3'd3,
        S_POP   = 3'd4
    } state_t;

endpackage

`endif

// File: rtl/srmem_rd_sched_if.sv
// rtl/srmem_rd_sched_if.sv - source, srmem and PCU signals of srmem_rd_sched (timeout_err with SRMEM_SCHED_TIMEOUT_EN)
interface srmem_rd_sched_if
    import srmem_rd_sched_pkg::*;
#(
    parameter int NUM_PCU = NUM_PCU_DEF,
    parameter int DATA_BW = PCHINFO_BW_DEF
) ();

    logic               src_valid;
    logic [DATA_BW-1:0] src_data;
    logic               src_last;
    logic               src_ready;
    logic               wrfull;
    logic               rdvalid;
    logic               rdlast;
    logic               rdend;
    logic               valid_din;
    logic [DATA_BW-1:0] din;
    logic               is_lastdin;
    logic               req_pop;
    logic               req_newdata;
    logic [NUM_PCU-1:0] pcu_en;
    logic [NUM_PCU-1:0] pcu_start;
    logic [NUM_PCU-1:0] pcu_done;
    logic               sched_busy;
`ifdef SRMEM_SCHED_TIMEOUT_EN
    logic               timeout_err;
`endif

    modport master (
        input  src_valid, src_data, src_last, wrfull, rdvalid, rdlast, rdend,
               pcu_en, pcu_done,
        output src_ready, valid_din, din, is_lastdin, req_pop, req_newdata,
               pcu_start, sched_busy
`ifdef SRMEM_SCHED_TIMEOUT_EN
        , output timeout_err
`endif
    );

    modport slave (
        output src_valid, src_data, src_last, wrfull, rdvalid, rdlast, rdend,
               pcu_en, pcu_done,
        input  src_ready, valid_din, din, is_lastdin, req_pop, req_newdata,
               pcu_start, sched_busy
`ifdef SRMEM_SCHED_TIMEOUT_EN
        , input timeout_err
`endif
    );

endinterface

// File: rtl/srmem_done_collect.sv
// rtl/srmem_done_collect.sv - per-row done collection across the PCU array
module srmem_done_collect
    import srmem_rd_sched_pkg::*;
#(
    parameter int NUM_PCU = NUM_PCU_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               row_start,
    input  logic               collect,
    input  logic [NUM_PCU-1:0] pcu_en,
    input  logic [NUM_PCU-1:0] pcu_done,
    output logic               all_done
);

    logic [NUM_PCU-1:0] en_q;
    logic [NUM_PCU-1:0] done_vec;

    // Disabled PCUs count as done from row start; only enabled ones can set their bit later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= '0;
            done_vec <= '0;
        end else if (row_start) begin
            en_q     <= pcu_en;
            done_vec <= ~pcu_en;
        end else if (collect) begin
            done_vec <= done_vec | (pcu_done & en_q);
        end
    end

    assign all_done = &done_vec;

endmodule

// File: rtl/srmem_rd_sched.sv
// rtl/srmem_rd_sched.sv - load/serve/pop sequencer for one shift-register memory (optional SRMEM_SCHED_TIMEOUT_EN)
module srmem_rd_sched
    import srmem_rd_sched_pkg::*;
#(
    parameter int NUM_PCU   = NUM_PCU_DEF,
    parameter int LEN_SRMEM = LEN_SRMEM_DEF,
    parameter int DATA_BW   = PCHINFO_BW_DEF
`ifdef SRMEM_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    srmem_rd_sched_if.master bus
);

    localparam int             RCW     = `LOG2(LEN_SRMEM);
    localparam logic [RCW-1:0] ROW_MAX = RCW'(LEN_SRMEM - 1);
`ifdef SRMEM_SCHED_TIMEOUT_EN
    localparam int             TCW     = `LOG2(TIMEOUT);
    localparam logic [TCW-1:0] TO_MAX  = TCW'(TIMEOUT - 1);
`endif

    state_t             state;
    logic               src_ready;
    logic               accept;
    logic               row_start;
    logic               all_done;
    logic               req_pop_q;
    logic [NUM_PCU-1:0] pcu_start_q;
    logic               valid_din_q;
    logic [DATA_BW-1:0] din_q;
    logic               is_lastdin_q;
    logic [RCW-1:0]     row_cnt;
`ifdef SRMEM_SCHED_TIMEOUT_EN
    logic [TCW-1:0]     to_cnt;
    logic               timeout_err_q;
`endif

    // Upstream is only accepted while idle with room in srmem, or mid-batch.
    assign src_ready = !rst && ((state == S_IDLE && !bus.wrfull) || state == S_LOAD);
    assign accept    = bus.src_valid && src_ready;
    assign row_start = (state == S_WAIT) && bus.rdvalid;

    srmem_done_collect #(.NUM_PCU(NUM_PCU)) u_done (
        .clk       (clk),
        .rst       (rst),
        .row_start (row_start),
        .collect   (state == S_SERVE),
        .pcu_en    (bus.pcu_en),
        .pcu_done  (bus.pcu_done),
        .all_done  (all_done)
    );

    // Main sequencer: batch load, row hand-out, done wait, pop and refill decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            req_pop_q    <= 1'b0;
            pcu_start_q  <= '0;
            valid_din_q  <= 1'b0;
            din_q        <= '0;
            is_lastdin_q <= 1'b0;
            row_cnt      <= '0;
`ifdef SRMEM_SCHED_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            req_pop_q    <= 1'b0;
            pcu_start_q  <= '0;
            valid_din_q  <= accept;
            is_lastdin_q <= accept && bus.src_last;
            if (accept) begin
                din_q <= bus.src_data;
            end
            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        state <= bus.src_last ? S_WAIT : S_LOAD;
                    end
                end
                S_WAIT: begin
                    if (bus.rdvalid) begin
                        pcu_start_q <= bus.pcu_en;
                        state       <= S_SERVE;
`ifdef SRMEM_SCHED_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
                S_SERVE: begin
                    if (all_done) begin
                        req_pop_q <= 1'b1;
                        state     <= S_POP;
                    end
`ifdef SRMEM_SCHED_TIMEOUT_EN
                    else if (to_cnt == TO_MAX) begin
                        req_pop_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        state         <= S_POP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_POP: begin
                    row_cnt <= (row_cnt == ROW_MAX) ? '0 : row_cnt + 1'b1;
                    state   <= (bus.rdlast && bus.src_valid) ? S_LOAD : S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.src_ready   = src_ready;
    assign bus.valid_din   = valid_din_q;
    assign bus.din         = din_q;
    assign bus.is_lastdin  = is_lastdin_q;
    assign bus.req_pop     = req_pop_q;
    assign bus.req_newdata = (state == S_POP) && bus.rdlast && bus.src_valid;
    assign bus.pcu_start   = pcu_start_q;
    assign bus.sched_busy  = (state != S_IDLE);
`ifdef SRMEM_SCHED_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`endif

    // srmem flags its final row exactly when a refill is requested.
    assert property (@(posedge clk) disable iff (rst) bus.req_newdata |-> bus.rdend);
    assert property (@(posedge clk) disable iff (rst) row_cnt <= ROW_MAX);

endmodule

// File: tb/tb_srmem_rd_sched.sv
// tb/tb_srmem_rd_sched.sv - randomized directed bench for srmem_rd_sched (covers SRMEM_SCHED_TIMEOUT_EN when defined)
`timescale 1ns/1ps
module tb_srmem_rd_sched;

    localparam int NP  = 2;
    localparam int LEN = 2;
    localparam int BW  = 16;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    srmem_rd_sched_if #(.NUM_PCU(NP), .DATA_BW(BW)) bus ();

    srmem_rd_sched #(
        .NUM_PCU   (NP),
        .LEN_SRMEM (LEN),
        .DATA_BW   (BW)
`ifdef SRMEM_SCHED_TIMEOUT_EN
        , .TIMEOUT (TMO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_batch(input int n);
        logic [BW-1:0] d;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.src_valid = 1'b0;
                #1;
                chk("load_ready_gap", bus.src_ready, 1);
                tick();
                chk("load_gap_nowrite", bus.valid_din, 0);
            end
            d = BW'($urandom);
            bus.src_valid = 1'b1;
            bus.src_data  = d;
            bus.src_last  = (i == n - 1);
            #1;
            chk("load_ready", bus.src_ready, 1);
            tick();
            chk("din_valid", bus.valid_din, 1);
            chk("din_data", bus.din, d);
            chk("din_last", bus.is_lastdin, (i == n - 1));
        end
        bus.src_valid = 1'b0;
        bus.src_last  = 1'b0;
        #1;
        chk("ready_drop_after_last", bus.src_ready, 0);
        chk("busy_in_wait", bus.sched_busy, 1);
    endtask

    // Pop comes two cycles after the last enabled done; enabled done offsets are
    // counted from the pcu_start cycle, disabled PCUs spam done every cycle.
    task automatic serve_row(input logic [NP-1:0] en, input bit last, input bit newsrc);
        int            off [NP];
        int            last_off;
        int            pop_at;
        int            gap;
        logic [NP-1:0] dn;
        last_off = -1;
        for (int k = 0; k < NP; k++) begin
            off[k] = $urandom_range(0, 4);
            if (en[k] && off[k] > last_off) last_off = off[k];
        end
        pop_at     = last_off + 3;
        gap        = $urandom_range(0, 2);
        bus.rdlast = last;
        bus.rdend  = last;
        bus.pcu_en = en;
        for (int g = 0; g < gap; g++) begin
            bus.rdvalid = 1'b0;
            #1;
            chk("no_start_while_moving", bus.pcu_start, 0);
            tick();
        end
        for (int c = 0; c <= pop_at; c++) begin
            bus.rdvalid = (c == 0);
            dn = '0;
            if (c >= 1) begin
                for (int k = 0; k < NP; k++) dn[k] = en[k] ? (off[k] == c - 1) : 1'b1;
            end
            bus.pcu_done  = dn;
            bus.src_valid = (c == pop_at) && newsrc;
            if (c == 1) bus.pcu_en = ~en;
            #1;
            chk("pcu_start", bus.pcu_start, (c == 1) ? en : {NP{1'b0}});
            chk("req_pop", bus.req_pop, (c == pop_at));
            chk("req_newdata", bus.req_newdata, (c == pop_at) && last && newsrc);
            tick();
        end
        bus.pcu_done  = '0;
        bus.rdvalid   = 1'b0;
        bus.src_valid = 1'b0;
        #1;
        chk("ready_after_pop", bus.src_ready, last && newsrc);
        chk("single_pop", bus.req_pop, 0);
    endtask

    logic [NP-1:0] en_tab [4];

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        en_tab        = '{2'b11, 2'b01, 2'b00, 2'b10};
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.src_last  = 1'b0;
        bus.wrfull    = 1'b0;
        bus.rdvalid   = 1'b0;
        bus.rdlast    = 1'b0;
        bus.rdend     = 1'b0;
        bus.pcu_en    = '0;
        bus.pcu_done  = '0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_valid_din", bus.valid_din, 0);
        chk("rst_din", bus.din, 0);
        chk("rst_is_lastdin", bus.is_lastdin, 0);
        chk("rst_req_pop", bus.req_pop, 0);
        chk("rst_req_newdata", bus.req_newdata, 0);
        chk("rst_pcu_start", bus.pcu_start, 0);
        chk("rst_busy", bus.sched_busy, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            bus.wrfull = (i % 2 == 0);
            #1;
            chk("idle_ready", bus.src_ready, (i % 2 != 0));
            chk("idle_busy", bus.sched_busy, 0);
            tick();
        end
        bus.wrfull    = 1'b1;
        bus.src_valid = 1'b1;
        tick();
        chk("idle_full_noaccept", bus.valid_din, 0);
        chk("idle_full_stays", bus.sched_busy, 0);
        bus.src_valid = 1'b0;
        bus.wrfull    = 1'b0;

        for (int b = 0; b < 3; b++) begin
            load_batch(NP * LEN);
            for (int r = 0; r < LEN - 1; r++) begin
                serve_row((b == 0) ? en_tab[r] : NP'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            end
            serve_row((b == 0) ? en_tab[2] : NP'($urandom), 1'b1, 1'b0);
            serve_row((b == 0) ? en_tab[3] : NP'($urandom), 1'b1, 1'b1);
        end

        load_batch(NP * LEN);
        bus.pcu_en  = {NP{1'b1}};
        bus.rdvalid = 1'b1;
        bus.rdlast  = 1'b0;
        bus.rdend   = 1'b0;
        tick();
        bus.rdvalid = 1'b0;
        chk("mid_serve_start", bus.pcu_start, {NP{1'b1}});
        bus.wrfull = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_pcu_start", bus.pcu_start, 0);
        chk("async_rst_din", bus.din, 0);
        chk("async_rst_valid_din", bus.valid_din, 0);
        chk("async_rst_req_pop", bus.req_pop, 0);
        chk("async_rst_busy", bus.sched_busy, 0);
        chk("async_rst_ready", bus.src_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_ready_full", bus.src_ready, 0);
        bus.wrfull = 1'b0;
        #1;
        chk("post_rst_ready", bus.src_ready, 1);
        bus.pcu_done = {NP{1'b1}};
        tick();
        bus.pcu_done = '0;
        chk("idle_done_ignored", bus.req_pop, 0);
        chk("post_rst_idle", bus.sched_busy, 0);

`ifdef SRMEM_SCHED_TIMEOUT_EN
        chk("timeout_err_rst", bus.timeout_err, 0);
        load_batch(NP * LEN);
        bus.pcu_en = {NP{1'b1}};
        for (int c = 0; c <= TMO + 1; c++) begin
            bus.rdvalid = (c == 0);
            #1;
            chk("to_req_pop", bus.req_pop, (c == TMO + 1));
            chk("to_err", bus.timeout_err, (c == TMO + 1));
            tick();
        end
        bus.rdvalid = 1'b0;
        repeat (3) tick();
        chk("to_err_sticky", bus.timeout_err, 1);
        chk("to_single_pop", bus.req_pop, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srmem_rd_sched.md
Name: srmem_rd_sched

Overview:
- Sequencer and arbiter for one srmem_single_ctrl-managed shift-register memory.
- Load side: streams a pchinfo batch from upstream into the memory.
- Read side: distributes each head row to the NUM_PCU consumers and issues req_pop only after every enabled PCU reports done.
- Decides req_newdata at the last row, based on whether a new batch is already waiting. Sits between the patch-info source and the PCU array.

Parameters:
- NUM_PCU, `NUM_PCU, number of consumers (= read ports).
- LEN_SRMEM, (`NUM_PCH/`NUM_PCU), rows per batch.
- DATA_BW, `PCHINFO_BW, entry width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- src_valid  in  1  upstream entry valid.
- src_data  in  DATA_BW  upstream entry.
- src_last  in  1  last entry of batch.
- src_ready  out  1  upstream accept.
- wrfull  in  1  srmem status.
- rdvalid  in  1  srmem status.
- rdlast  in  1  srmem status.
- rdend  in  1  srmem status.
- valid_din  out  1  write strobe to srmem.
- din  out  DATA_BW  write data to srmem.
- is_lastdin  out  1  last-entry flag to srmem.
- req_pop  out  1  pop the head row.
- req_newdata  out  1  accompanies the final pop; requests refill.
- pcu_en  in  NUM_PCU  consumer enable mask; sampled at row start.
- pcu_start  out  NUM_PCU  1-cycle pulse: head row valid for that PCU.
- pcu_done  in  NUM_PCU  1-cycle pulse: PCU finished current row.
- sched_busy  out  1  high in any state except S_IDLE.

Behaviour:
- Reset (async): state S_IDLE, all outputs 0, done_vec 0, en_q 0, row_cnt 0.
- FSM states:
  - S_IDLE: src_ready = ~wrfull. First accepted entry -> S_LOAD.
  - S_LOAD: accepted when src_valid & src_ready. Registered pass-through, 1-cycle latency: valid_din/din/is_lastdin = registered (src_valid&src_ready, src_data, src_last). Accepted src_last -> S_WAIT, src_ready 0 from the next cycle.
  - S_WAIT: wait for rdvalid (covers srmem MOVING cycles). On rdvalid: en_q <= pcu_en, pcu_start <= pcu_en for one cycle, done_vec <= ~pcu_en -> S_SERVE.
  - S_SERVE: done_vec |= pcu_done. Duplicate dones are harmless. Dones for disabled PCUs are ignored. When done_vec all ones -> S_POP.
  - S_POP: req_pop = 1 for exactly one cycle. If rdlast, req_newdata = src_valid in the same cycle (new batch pending).
    - rdlast & req_newdata -> S_LOAD, src_ready = 1 next cycle.
    - rdlast & ~req_newdata -> S_WAIT; srmem retains/rereads the data.
    - otherwise -> S_WAIT for the next row.
- Row hand-out latency: rdvalid to pcu_start = 1 cycle. Final pcu_done to req_pop = 2 cycles (S_SERVE then S_POP).
- row_cnt (log2(LEN_SRMEM) bits): increments per pop, wraps to 0 after LEN_SRMEM-1. Diagnostic only.
- pcu_en == 0 at row start: done_vec is immediately all ones; the pop is issued with no pcu_start.
- pcu_done outside S_SERVE is ignored.
- src_valid without src_last for more than LEN_SRMEM*NUM_PCU entries is not checked (source contract).
- rdend is not used for control; it is an assertion-only cross-check that it coincides with req_newdata.

Optional Feature:
- SRMEM_SCHED_TIMEOUT_EN defined:
  - Parameter TIMEOUT (default 1024) and output timeout_err (1 bit, sticky until rst).
  - A cycle counter in S_SERVE that reaches TIMEOUT forces S_POP and sets timeout_err.
- Undefined: no counter, no timeout_err port; S_SERVE waits indefinitely.

Decomposition:
- Shared package/define file holds:
  - state encodings S_IDLE..S_POP (3 bits);
  - the `log2 macro;
  - defaults from define.v;
  - the TIMEOUT default.
- One natural sub-module: srmem_done_collect. It holds done_vec, en_q and the all-done detect, and is parameterized by NUM_PCU.

Test Plan (NUM_PCU=2, LEN_SRMEM=2):
- Load: send 4 entries A,B,C,D, last on D -> valid_din high 4 cycles, each 1 cycle after acceptance; is_lastdin with D; src_ready 0 after D.
- Row serve: rdvalid=1, pcu_en=2'b11 -> pcu_start=2'b11 next cycle. pcu_done[0] at t, pcu_done[1] at t+3 -> single req_pop at t+5.
- Masked PCU: pcu_en=2'b01 -> pcu_start=2'b01; pcu_done[0] alone triggers req_pop 2 cycles later; pcu_done[1] ignored.
- Last row with src_valid=1 -> req_pop & req_newdata same cycle, then S_LOAD with src_ready=1. Without src_valid -> req_newdata=0, back to S_WAIT.
- Async rst asserted mid S_SERVE -> all outputs 0 immediately. After release, state S_IDLE and src_ready = ~wrfull.
- With SRMEM_SCHED_TIMEOUT_EN and TIMEOUT=8: no pcu_done for 8 cycles -> req_pop forced, timeout_err=1 and stays 1.
